ps2_keystroke: RTL and testbench
================================

# ps2_keystroke

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and turns them into a held scan code on `key_stroke[7:0]`. It sits directly upstream of the VGA note-display block, which decodes `key_stroke` into a note name and shows `00` when no key is held. The block filters and synchronizes the pins, deframes 11-bit frames with parity and stop checks, and tracks break (`F0`) and extended (`E0`) prefixes. The held code stays valid until the matching key is released.

## Interface
- `FILTER_LEN`, 4: number of consecutive identical synchronized samples required before the filtered `ps2_clk` changes level (range 2..15).
- `TIMEOUT_CYCLES`, 20000: number of idle `clk` cycles between filtered falling edges inside a frame that aborts the frame (200 µs at 100 MHz).
- `clk` in 1: system clock. All state is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `key_stroke` out 8: currently held make code; `8'h00` when no key is held.
- `extended` out 1: high when the held code was preceded by `E0`.
- `key_valid` out 1: one-cycle pulse on every accepted make code, including typematic repeats.
- `key_release` out 1: one-cycle pulse when the held key's break code is accepted.
- `frame_err` out 1: one-cycle pulse on a parity, start, stop, or timeout error.
- `err_count` out 8: count of frame errors, saturating at 255.

## Operation
- Input path: each pin goes through a 2-flop synchronizer. The synchronized clock then goes through a glitch filter of `FILTER_LEN` samples. A falling edge (`fall`) is the cycle the filtered clock goes from 1 to 0. Data is sampled from synchronized `ps2_data` on the `fall` cycle.
- Deframer FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, if data is 0 go to DATA with bit count 0 and the timeout counter cleared. If data is 1, flag a start error and stay in IDLE.
  - DATA: on `fall`, shift the bit in LSB-first. After the 8th bit go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, check that the stop bit is 1 and that the 8 data bits plus the parity bit contain an odd number of ones.
    - Pass: deliver the byte and return to IDLE.
    - Fail: raise `frame_err` and return to IDLE.
- Timeout: in any state except IDLE, the counter increments every cycle and clears on `fall`. Reaching `TIMEOUT_CYCLES` gives `frame_err` and a return to IDLE with the partial byte discarded.
- Byte interpretation:
  - `E0`: set `ext_pend`.
  - `F0`: set `brk_pend`.
  - Any other byte with `brk_pend` = 1: clear both pendings. If the byte equals `key_stroke` and `ext_pend` matches `extended`, then `key_stroke` becomes `00`, `extended` becomes 0, and `key_release` pulses. Otherwise nothing else happens.
  - Any other byte with `brk_pend` = 0: `key_stroke` becomes the byte, `extended` becomes `ext_pend`, `key_valid` pulses, and both pendings clear.
- Any frame error clears `ext_pend` and `brk_pend`; `key_stroke` and `extended` are unchanged.
- `err_count` increments on each `frame_err` and saturates at 255. Only reset clears it.

## Timing
- Reset values: `key_stroke` = 00, `extended` = 0, `key_valid` = 0, `key_release` = 0, `frame_err` = 0, `err_count` = 0. FSM in IDLE, pendings 0, synchronizers and filter at 1 (bus idle).
- Asserting `rst` mid-frame aborts the frame immediately. After reset is released, the remaining edges of that frame produce start or framing errors, or a timeout; they never produce a spurious make code.
- Pin to `fall` latency: 2 synchronizer cycles + `FILTER_LEN` filter cycles + 1 cycle.
- Outputs (`key_stroke`, `extended`, and the pulses) are registered. They update on the `clk` edge after the `fall` cycle of the stop bit or of the timeout terminal count.
- Pulses last exactly one cycle. `key_valid`, `key_release`, and `frame_err` are mutually exclusive.
- Glitches shorter than `FILTER_LEN` cycles on `ps2_clk` produce no `fall`.

## Test plan
- Make: frame `1C` (parity 0, stop 1). Required: `key_stroke` = `1C`, `extended` = 0, one `key_valid` pulse, `err_count` = 0.
- Break: `1C`, then `F0`, then `1C`. Required: after `F0` there is no output change; after the final `1C`, `key_stroke` = 00 and one `key_release` pulse.
- Extended and mismatched break: `E0`, `75` gives `key_stroke` = `75` and `extended` = 1. Then `F0`, `75` without a preceding `E0` leaves `key_stroke` = `75` with no `key_release`.
- Parity and stop errors:
  - `1C` sent with parity 1: one `frame_err`, `err_count` = 1, `key_stroke` unchanged.
  - `F0` with stop 0, then `1B`: `err_count` = 2, and `1B` is treated as a make (`key_stroke` = `1B`).
- Timeout and glitch:
  - Stop `ps2_clk` after 4 data bits for more than `TIMEOUT_CYCLES`: `frame_err` fires, FSM returns to IDLE, and a following valid `23` gives `key_stroke` = `23`.
  - A 2-cycle low glitch on `ps2_clk` with `FILTER_LEN` = 4 produces no bit.
- Reset mid-frame: assert `rst` after 5 bits of `42`. Required: all outputs at reset values, and the next full `34` frame yields `key_stroke` = `34`.

Source files
------------

// File: rtl/ps2_keystroke_if.sv
// PS/2 keystroke bundle: raw PS/2 pins in, held scan code and event pulses out.
// Slave modport is the receiver; master modport is whoever drives the pins.
// No backpressure: pulses are one-cycle events and the code is a level.
interface ps2_keystroke_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_stroke;
    logic       extended;
    logic       key_valid;
    logic       key_release;
    logic       frame_err;
    logic [7:0] err_count;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key_stroke,
        output extended,
        output key_valid,
        output key_release,
        output frame_err,
        output err_count
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key_stroke,
        input  extended,
        input  key_valid,
        input  key_release,
        input  frame_err,
        input  err_count
    );
endinterface

// File: rtl/ps2_keystroke.sv
// PS/2 keyboard receiver: sync + glitch-filter pins, deframe 11-bit frames, track E0/F0, hold make code.
// Latency: pin edge to fall = 2 sync + FILTER_LEN filter + 1; outputs register one clk after the stop-bit fall.
// No backpressure: the keyboard cannot be stalled, so every accepted byte is acted on immediately.
module ps2_keystroke #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic            clk,
    input  logic            rst_n,
    ps2_keystroke_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Input path registers; idle bus is high so everything resets to 1.
    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [3:0]    r_fcnt;
    logic          w_fall;

    // Deframer state.
    state_t        r_state, w_state_nx;
    logic [2:0]    r_bitcnt, w_bitcnt_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic          r_par, w_par_nx;
    logic [TW-1:0] r_tmo, w_tmo_nx;
    logic          w_byte_vld, w_err;

    // Byte interpretation / output state.
    logic [7:0]    r_key, r_ecnt;
    logic          r_ext, r_kv, r_kr, r_fe, r_ext_pend, r_brk_pend;

    // Two-flop synchronizers on both pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= bus.ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= bus.ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == 4'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 4'd1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt;

    // Deframer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_shift  <= w_shift_nx;
            r_par    <= w_par_nx;
            r_tmo    <= w_tmo_nx;
        end
    end

    // Deframer next state: one bit per filtered falling edge, timeout while mid-frame.
    always_comb begin
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt;
        w_shift_nx  = r_shift;
        w_par_nx    = r_par;
        w_tmo_nx    = w_fall ? '0 : r_tmo + TW'(1);
        w_byte_vld  = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                w_tmo_nx = '0;
                if (w_fall) begin
                    if (!r_dat_s2) begin
                        w_state_nx  = DATA;
                        w_bitcnt_nx = '0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_fall) begin
                    w_shift_nx = {r_dat_s2, r_shift[7:1]};
                    if (r_bitcnt == 3'd7) w_state_nx = PARITY;
                    else                  w_bitcnt_nx = r_bitcnt + 3'd1;
                end
            end
            PARITY: begin
                if (w_fall) begin
                    w_par_nx   = r_dat_s2;
                    w_state_nx = STOP;
                end
            end
            STOP: begin
                if (w_fall) begin
                    w_state_nx = IDLE;
                    if (r_dat_s2 && (^{r_shift, r_par})) w_byte_vld = 1'b1;
                    else                                 w_err      = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        // A stalled keyboard mid-frame drops the partial byte.
        if (r_state != IDLE && !w_fall && r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            w_err      = 1'b1;
            w_state_nx = IDLE;
            w_tmo_nx   = '0;
        end
    end

    // Byte interpretation: prefix tracking, held code, pulses and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key      <= 8'h00;
            r_ext      <= 1'b0;
            r_kv       <= 1'b0;
            r_kr       <= 1'b0;
            r_fe       <= 1'b0;
            r_ecnt     <= 8'h00;
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else begin
            r_kv <= 1'b0;
            r_kr <= 1'b0;
            r_fe <= 1'b0;
            if (w_err) begin
                r_fe       <= 1'b1;
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
                if (r_ecnt != 8'hFF) r_ecnt <= r_ecnt + 8'd1;
            end else if (w_byte_vld) begin
                if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else if (r_brk_pend) begin
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                    if (r_shift == r_key && r_ext_pend == r_ext) begin
                        r_key <= 8'h00;
                        r_ext <= 1'b0;
                        r_kr  <= 1'b1;
                    end
                end else begin
                    r_key      <= r_shift;
                    r_ext      <= r_ext_pend;
                    r_kv       <= 1'b1;
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end
            end
        end
    end

    assign bus.key_stroke  = r_key;
    assign bus.extended    = r_ext;
    assign bus.key_valid   = r_kv;
    assign bus.key_release = r_kr;
    assign bus.frame_err   = r_fe;
    assign bus.err_count   = r_ecnt;
endmodule

// File: tb/tb_ps2_keystroke.sv
// Directed bench for ps2_keystroke: table of frames with expected held state and pulse counts,
// followed by hand-written timeout, glitch and mid-frame reset sequences.
module tb_ps2_keystroke;
    localparam int FLEN = 4;
    localparam int TMO  = 400;
    localparam int HALF = 20;

    logic clk;
    logic rst_n;
    ps2_keystroke_if bus ();

    ps2_keystroke #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Cycle counts of each pulse, plus cycles where more than one pulse was high.
    int n_kv = 0, n_kr = 0, n_fe = 0, n_multi = 0;
    always @(negedge clk) begin
        if (bus.key_valid)   n_kv <= n_kv + 1;
        if (bus.key_release) n_kr <= n_kr + 1;
        if (bus.frame_err)   n_fe <= n_fe + 1;
        if (int'(bus.key_valid) + int'(bus.key_release) + int'(bus.frame_err) > 1)
            n_multi <= n_multi + 1;
    end

    typedef struct {
        logic [7:0] dat;
        logic       bad_par;
        logic       stop;
        logic [7:0] exp_key;
        logic       exp_ext;
        int         exp_kv;
        int         exp_kr;
        int         exp_fe;
        int         exp_ecnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par, input logic stop);
        logic p;
        p = (~^d) ^ bad_par;
        return {stop, p, d, 1'b0};
    endfunction

    // Drive frame bits lo..hi (index 0 = start), data set mid-high, then a full low phase.
    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    int kv0, kr0, fe0;
    task automatic snap();
        kv0 = n_kv;
        kr0 = n_kr;
        fe0 = n_fe;
    endtask

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1, 0, 0, 0};  // make
        vecs[1]  = '{8'hF0, 1'b0, 1'b1, 8'h1C, 1'b0, 0, 0, 0, 0};  // break prefix: no change
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 8'h00, 1'b0, 0, 1, 0, 0};  // release
        vecs[3]  = '{8'hE0, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0, 0, 0};  // extended prefix
        vecs[4]  = '{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 1, 0, 0, 0};  // extended make
        vecs[5]  = '{8'hF0, 1'b0, 1'b1, 8'h75, 1'b1, 0, 0, 0, 0};
        vecs[6]  = '{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 0, 0, 0, 0};  // break without E0: ignored
        vecs[7]  = '{8'h1C, 1'b1, 1'b1, 8'h75, 1'b1, 0, 0, 1, 1};  // parity error
        vecs[8]  = '{8'hF0, 1'b0, 1'b0, 8'h75, 1'b1, 0, 0, 1, 2};  // stop error drops F0
        vecs[9]  = '{8'h1B, 1'b0, 1'b1, 8'h1B, 1'b0, 1, 0, 0, 2};  // so this is a make
        vecs[10] = '{8'h1B, 1'b0, 1'b1, 8'h1B, 1'b0, 1, 0, 0, 2};  // typematic repeat

        rst_n        = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        chk("rst_key",   int'(bus.key_stroke), 8'h00);
        chk("rst_ext",   int'(bus.extended), 0);
        chk("rst_pulse", int'({bus.key_valid, bus.key_release, bus.frame_err}), 0);
        chk("rst_ecnt",  int'(bus.err_count), 0);

        for (int v = 0; v < 11; v++) begin
            snap();
            send_bits(mk(vecs[v].dat, vecs[v].bad_par, vecs[v].stop), 0, 10);
            chk($sformatf("v%0d_key", v),  int'(bus.key_stroke), int'(vecs[v].exp_key));
            chk($sformatf("v%0d_ext", v),  int'(bus.extended),   int'(vecs[v].exp_ext));
            chk($sformatf("v%0d_kv", v),   n_kv - kv0, vecs[v].exp_kv);
            chk($sformatf("v%0d_kr", v),   n_kr - kr0, vecs[v].exp_kr);
            chk($sformatf("v%0d_fe", v),   n_fe - fe0, vecs[v].exp_fe);
            chk($sformatf("v%0d_ecnt", v), int'(bus.err_count), vecs[v].exp_ecnt);
        end

        // Timeout: start + 4 data bits then the clock stops.
        snap();
        send_bits(mk(8'h5A, 1'b0, 1'b1), 0, 4);
        repeat (TMO + 50) @(negedge clk);
        chk("tmo_fe",   n_fe - fe0, 1);
        chk("tmo_ecnt", int'(bus.err_count), 3);
        chk("tmo_key",  int'(bus.key_stroke), 8'h1B);
        snap();
        send_bits(mk(8'h23, 1'b0, 1'b1), 0, 10);
        chk("tmo_next_key", int'(bus.key_stroke), 8'h23);
        chk("tmo_next_kv",  n_kv - kv0, 1);
        chk("tmo_next_fe",  n_fe - fe0, 0);

        // Glitch: 2-cycle low pulse on ps2_clk with data low must not start a frame.
        snap();
        bus.ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        bus.ps2_data = 1'b1;
        send_bits(mk(8'h2A, 1'b0, 1'b1), 0, 10);
        chk("glitch_key",  int'(bus.key_stroke), 8'h2A);
        chk("glitch_fe",   n_fe - fe0, 0);
        chk("glitch_ecnt", int'(bus.err_count), 3);

        // Reset mid-frame: start + 5 bits of 42, reset, then the rest of the frame.
        send_bits(mk(8'h42, 1'b0, 1'b1), 0, 5);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_key_in", int'(bus.key_stroke), 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_key",   int'(bus.key_stroke), 8'h00);
        chk("mrst_ext",   int'(bus.extended), 0);
        chk("mrst_pulse", int'({bus.key_valid, bus.key_release, bus.frame_err}), 0);
        chk("mrst_ecnt",  int'(bus.err_count), 0);
        snap();
        send_bits(mk(8'h42, 1'b0, 1'b1), 6, 10);
        repeat (TMO + 50) @(negedge clk);
        chk("mrst_tail_kv",  n_kv - kv0, 0);
        chk("mrst_tail_key", int'(bus.key_stroke), 8'h00);
        chk("mrst_tail_fe",  n_fe - fe0, 1);
        snap();
        send_bits(mk(8'h34, 1'b0, 1'b1), 0, 10);
        chk("mrst_next_key", int'(bus.key_stroke), 8'h34);
        chk("mrst_next_kv",  n_kv - kv0, 1);
        chk("mrst_next_ext", int'(bus.extended), 0);

        chk("pulse_exclusive", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
